clock_enables: RTL and testbench



---
 rtl/clock_enables_pkg.sv | 22 ++
 rtl/nco_channel.sv | 75 +++++++
 rtl/clock_enables.sv | 44 ++++
 tb/tb_clock_enables.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_enables_pkg.sv
// Shared constants for the fractional-N clock-enable generator: default
// accumulator width, the 50 MHz machine-clock increments and an increment helper.
package clock_enables_pkg;

    localparam int DEF_ACC_WIDTH = 24;

    // 50 MHz system clock -> 7.0938 MHz pixel / 3.5469 MHz CPU at width 24
    localparam logic [23:0] INC_PIX_50M = 24'd2380284;
    localparam logic [23:0] INC_CPU_50M = 24'd1190142;

    // Rounded increment so that clk_hz * inc / 2^width is closest to f_hz
    function automatic longint unsigned calc_inc(
        input longint unsigned clk_hz,
        input longint unsigned f_hz,
        input int unsigned     width
    );
        longint unsigned scaled;
        scaled = (f_hz << width) + (clk_hz >> 1);
        return scaled / clk_hz;
    endfunction

endpackage

// File: rtl/nco_channel.sv
// One phase-accumulator channel: active/shadow increment pair with apply at a
// carry, sync or frozen state, emitting registered one-cycle enable pulses.
module nco_channel
    import clock_enables_pkg::*;
#(
    parameter int                   ACC_WIDTH = DEF_ACC_WIDTH,
    parameter logic [ACC_WIDTH-1:0] INC_INIT  = '0
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_sync,
    input  logic                 i_wr,
    input  logic [ACC_WIDTH-1:0] i_data,
    output logic                 o_ce,
    output logic                 o_inc_ack,
    output logic                 o_inc_pending
);

    logic [ACC_WIDTH-1:0] r_acc;
    logic [ACC_WIDTH-1:0] r_inc_act;
    logic [ACC_WIDTH-1:0] r_inc_shd;
    logic                 r_pend;
    logic                 r_ce;
    logic                 r_ack;

    logic [ACC_WIDTH:0]   w_sum;
    logic                 w_carry;
    logic                 w_frozen;
    logic                 w_apply;

    assign w_sum    = {1'b0, r_acc} + {1'b0, r_inc_act};
    assign w_carry  = w_sum[ACC_WIDTH];
    assign w_frozen = (r_inc_act == '0);
    // Switching only at a carry keeps the accumulated phase continuous
    assign w_apply  = r_pend & (w_carry | i_sync | w_frozen);

    // Phase accumulator and enable pulse
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_acc <= '0;
            r_ce  <= 1'b0;
        end else if (i_sync) begin
            r_acc <= '0;
            r_ce  <= 1'b0;
        end else begin
            r_acc <= w_sum[ACC_WIDTH-1:0];
            r_ce  <= w_carry;
        end
    end

    // Shadow/active increment handoff
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_inc_act <= INC_INIT;
            r_inc_shd <= '0;
            r_pend    <= 1'b0;
            r_ack     <= 1'b0;
        end else begin
            r_ack <= w_apply;
            if (w_apply) begin
                r_inc_act <= r_inc_shd;
            end
            if (i_wr) begin
                r_inc_shd <= i_data;
            end
            // A write landing on the apply cycle stays pending for the next one
            r_pend <= i_wr | (r_pend & ~w_apply);
        end
    end

    assign o_ce          = r_ce;
    assign o_inc_ack     = r_ack;
    assign o_inc_pending = r_pend;

endmodule

// File: rtl/clock_enables.sv
// Fractional-N clock-enable generator: CHANNELS independent NCO channels sharing
// one system clock, a broadcast phase-alignment sync and a selectable write port.
module clock_enables
    import clock_enables_pkg::*;
#(
    parameter int                            CHANNELS  = 2,
    parameter int                            ACC_WIDTH = DEF_ACC_WIDTH,
    parameter logic [CHANNELS*ACC_WIDTH-1:0] INC_RESET = {INC_PIX_50M, INC_CPU_50M}
) (
    input  logic                                               i_clock,
    input  logic                                               i_reset,
    input  logic                                               i_sync,
    input  logic                                               i_inc_wr,
    input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] i_inc_sel,
    input  logic [ACC_WIDTH-1:0]                               i_inc_data,
    output logic [CHANNELS-1:0]                                o_inc_pending,
    output logic [CHANNELS-1:0]                                o_inc_ack,
    output logic [CHANNELS-1:0]                                o_ce
);

    localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [CHANNELS-1:0] w_wr;

    // Selects beyond the last channel match no instance and are dropped
    for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
        assign w_wr[n] = i_inc_wr & (i_inc_sel == SEL_W'(n));

        nco_channel #(
            .ACC_WIDTH (ACC_WIDTH),
            .INC_INIT  (INC_RESET[n*ACC_WIDTH +: ACC_WIDTH])
        ) u_nco (
            .i_clock       (i_clock),
            .i_reset       (i_reset),
            .i_sync        (i_sync),
            .i_wr          (w_wr[n]),
            .i_data        (i_inc_data),
            .o_ce          (o_ce[n]),
            .o_inc_ack     (o_inc_ack[n]),
            .o_inc_pending (o_inc_pending[n])
        );
    end

endmodule

// File: tb/tb_clock_enables.sv
// Directed bench: a 4-bit, 3-channel instance (inc 4/3/0) for hand-computed
// pulse timing, plus a default instance for the long-run 50 MHz rates.
module tb_clock_enables;

    logic       clk;
    logic       rst;
    logic       sync;
    logic       wr;
    logic [1:0] sel;
    logic [3:0] data;
    logic [2:0] pend;
    logic [2:0] ack;
    logic [2:0] ce;

    logic        rst_d;
    logic        sync_d;
    logic        wr_d;
    logic        sel_d;
    logic [23:0] data_d;
    logic [1:0]  pend_d;
    logic [1:0]  ack_d;
    logic [1:0]  ce_d;

    int checks;
    int failures;

    clock_enables #(
        .CHANNELS  (3),
        .ACC_WIDTH (4),
        .INC_RESET ({4'd0, 4'd3, 4'd4})
    ) dut (
        .i_clock       (clk),
        .i_reset       (rst),
        .i_sync        (sync),
        .i_inc_wr      (wr),
        .i_inc_sel     (sel),
        .i_inc_data    (data),
        .o_inc_pending (pend),
        .o_inc_ack     (ack),
        .o_ce          (ce)
    );

    clock_enables dut_d (
        .i_clock       (clk),
        .i_reset       (rst_d),
        .i_sync        (sync_d),
        .i_inc_wr      (wr_d),
        .i_inc_sel     (sel_d),
        .i_inc_data    (data_d),
        .o_inc_pending (pend_d),
        .o_inc_ack     (ack_d),
        .o_ce          (ce_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        sync = 1'b0;
        wr   = 1'b0;
        sel  = 2'd0;
        data = 4'd0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        sync = 1'b1;
        step();
        step();
        checks++;
        if (ce !== 3'b000) begin
            failures++;
            $display("FAIL reset_ce: got %b expected %b", ce, 3'b000);
        end
        checks++;
        if (ack !== 3'b000) begin
            failures++;
            $display("FAIL reset_ack: got %b expected %b", ack, 3'b000);
        end
        checks++;
        if (pend !== 3'b000) begin
            failures++;
            $display("FAIL reset_pending: got %b expected %b", pend, 3'b000);
        end
        checks++;
        if (ce_d !== 2'b00) begin
            failures++;
            $display("FAIL reset_ce_default: got %b expected %b", ce_d, 2'b00);
        end
        sync = 1'b0;
    endtask

    task automatic test_rate_w4();
        logic [15:0] c0, c1, c2;
        logic [2:0]  ack_any;
        int          n1;
        do_reset();
        ack_any = 3'b000;
        for (int k = 0; k < 16; k++) begin
            step();
            c0[k]   = ce[0];
            c1[k]   = ce[1];
            c2[k]   = ce[2];
            ack_any = ack_any | ack;
        end
        checks++;
        if (c0 !== 16'b1000_1000_1000_1000) begin
            failures++;
            $display("FAIL rate_inc4: got %b expected %b", c0, 16'b1000_1000_1000_1000);
        end
        checks++;
        if (c1 !== 16'b1000_0100_0010_0000) begin
            failures++;
            $display("FAIL rate_inc3: got %b expected %b", c1, 16'b1000_0100_0010_0000);
        end
        checks++;
        if (c2 !== 16'b0) begin
            failures++;
            $display("FAIL rate_inc0_frozen: got %b expected %b", c2, 16'b0);
        end
        checks++;
        if (ack_any !== 3'b000) begin
            failures++;
            $display("FAIL rate_no_ack: got %b expected %b", ack_any, 3'b000);
        end
        n1 = 0;
        for (int k = 0; k < 16; k++) begin
            step();
            if (ce[1] === 1'b1) n1++;
        end
        checks++;
        if (n1 != 3) begin
            failures++;
            $display("FAIL rate_inc3_count16: got %0d expected %0d", n1, 3);
        end
    endtask

    task automatic test_zero_inc();
        logic [17:0] p0, a0, c0;
        do_reset();
        for (int k = 0; k < 18; k++) begin
            wr   = (k == 0) || (k == 12);
            sel  = 2'd0;
            data = (k == 0) ? 4'd0 : 4'd8;
            step();
            p0[k] = pend[0];
            a0[k] = ack[0];
            c0[k] = ce[0];
        end
        wr = 1'b0;
        checks++;
        if (p0 !== 18'b00_0001_0000_0000_0111) begin
            failures++;
            $display("FAIL zero_inc_pending: got %b expected %b", p0, 18'b00_0001_0000_0000_0111);
        end
        checks++;
        if (a0 !== 18'b00_0010_0000_0000_1000) begin
            failures++;
            $display("FAIL zero_inc_ack: got %b expected %b", a0, 18'b00_0010_0000_0000_1000);
        end
        checks++;
        if (c0 !== 18'b10_1000_0000_0000_1000) begin
            failures++;
            $display("FAIL zero_inc_ce: got %b expected %b", c0, 18'b10_1000_0000_0000_1000);
        end
    endtask

    task automatic test_sync();
        logic [9:0] c0, c1, a1, p1, other;
        do_reset();
        other = 10'b0;
        for (int k = 0; k < 10; k++) begin
            wr   = (k == 1);
            sel  = 2'd1;
            data = 4'd5;
            sync = (k == 3);
            step();
            c0[k]    = ce[0];
            c1[k]    = ce[1];
            a1[k]    = ack[1];
            p1[k]    = pend[1];
            other[k] = ce[2] | ack[0] | ack[2] | pend[0] | pend[2];
        end
        wr   = 1'b0;
        sync = 1'b0;
        checks++;
        if (c0 !== 10'b00_1000_0000) begin
            failures++;
            $display("FAIL sync_ce0: got %b expected %b", c0, 10'b00_1000_0000);
        end
        checks++;
        if (c1 !== 10'b00_1000_0000) begin
            failures++;
            $display("FAIL sync_ce1: got %b expected %b", c1, 10'b00_1000_0000);
        end
        checks++;
        if (a1 !== 10'b00_0000_1000) begin
            failures++;
            $display("FAIL sync_apply_ack: got %b expected %b", a1, 10'b00_0000_1000);
        end
        checks++;
        if (p1 !== 10'b00_0000_0110) begin
            failures++;
            $display("FAIL sync_apply_pending: got %b expected %b", p1, 10'b00_0000_0110);
        end
        checks++;
        if (other !== 10'b0) begin
            failures++;
            $display("FAIL sync_other_channels: got %b expected %b", other, 10'b0);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] a1, c1, p1, other;
        do_reset();
        other = 16'b0;
        for (int k = 0; k < 16; k++) begin
            wr   = (k == 1) || (k == 2) || (k == 6) || (k == 9) || (k == 12);
            sel  = (k == 6) ? 2'd3 : 2'd1;
            case (k)
                1:       data = 4'd5;
                2:       data = 4'd2;
                6:       data = 4'd9;
                9:       data = 4'd7;
                12:      data = 4'd1;
                default: data = 4'd0;
            endcase
            step();
            a1[k]    = ack[1];
            c1[k]    = ce[1];
            p1[k]    = pend[1];
            other[k] = pend[0] | pend[2] | ack[2] | ce[2];
        end
        wr = 1'b0;
        checks++;
        if (a1 !== 16'b1001_0000_0010_0000) begin
            failures++;
            $display("FAIL b2b_ack: got %b expected %b", a1, 16'b1001_0000_0010_0000);
        end
        checks++;
        if (c1 !== 16'b1001_0000_0010_0000) begin
            failures++;
            $display("FAIL b2b_ce: got %b expected %b", c1, 16'b1001_0000_0010_0000);
        end
        checks++;
        if (p1 !== 16'b0111_1110_0001_1110) begin
            failures++;
            $display("FAIL b2b_pending: got %b expected %b", p1, 16'b0111_1110_0001_1110);
        end
        checks++;
        if (other !== 16'b0) begin
            failures++;
            $display("FAIL b2b_bad_sel_ignored: got %b expected %b", other, 16'b0);
        end
    endtask

    task automatic test_reset_pending();
        logic [7:0] c1;
        logic [2:0] ack_any;
        do_reset();
        wr   = 1'b1;
        sel  = 2'd1;
        data = 4'd5;
        step();
        wr = 1'b0;
        checks++;
        if (pend !== 3'b010) begin
            failures++;
            $display("FAIL rstpend_set: got %b expected %b", pend, 3'b010);
        end
        rst  = 1'b1;
        sync = 1'b1;
        step();
        checks++;
        if ({pend, ack, ce} !== 9'b0) begin
            failures++;
            $display("FAIL rstpend_cleared: got %b expected %b", {pend, ack, ce}, 9'b0);
        end
        sync = 1'b0;
        step();
        rst     = 1'b0;
        ack_any = 3'b000;
        for (int k = 0; k < 8; k++) begin
            step();
            c1[k]   = ce[1];
            ack_any = ack_any | ack;
        end
        checks++;
        if (c1 !== 8'b0010_0000) begin
            failures++;
            $display("FAIL rstpend_inc_restored: got %b expected %b", c1, 8'b0010_0000);
        end
        checks++;
        if (ack_any !== 3'b000) begin
            failures++;
            $display("FAIL rstpend_no_ack: got %b expected %b", ack_any, 3'b000);
        end
    endtask

    task automatic test_rate_default();
        int n0, n1, f0, f1;
        n0 = 0;
        n1 = 0;
        f0 = -1;
        f1 = -1;
        rst_d = 1'b0;
        for (int k = 1; k <= 50000; k++) begin
            step();
            if (ce_d[0] === 1'b1) begin
                n0++;
                if (f0 < 0) f0 = k;
            end
            if (ce_d[1] === 1'b1) begin
                n1++;
                if (f1 < 0) f1 = k;
            end
        end
        checks++;
        if (f0 != 15) begin
            failures++;
            $display("FAIL default_first_ce0: got %0d expected %0d", f0, 15);
        end
        checks++;
        if (f1 != 8) begin
            failures++;
            $display("FAIL default_first_ce1: got %0d expected %0d", f1, 8);
        end
        checks++;
        if (n0 < 3546 || n0 > 3548) begin
            failures++;
            $display("FAIL default_count_ce0: got %0d expected 3547 +/-1", n0);
        end
        checks++;
        if (n1 < 7093 || n1 > 7095) begin
            failures++;
            $display("FAIL default_count_ce1: got %0d expected 7094 +/-1", n1);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        sync     = 1'b0;
        wr       = 1'b0;
        sel      = 2'd0;
        data     = 4'd0;
        rst_d    = 1'b1;
        sync_d   = 1'b0;
        wr_d     = 1'b0;
        sel_d    = 1'b0;
        data_d   = 24'd0;

        test_reset();
        test_rate_w4();
        test_zero_inc();
        test_sync();
        test_back_to_back();
        test_reset_pending();
        test_rate_default();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
